// File: rtl/svc_rv_bench_mon.sv
// Benchmark monitor for a RISC-V core: measurement-window FSM, saturating cycle/instret/event
// counters and a watchdog that forces DONE when the program never halts.
module svc_rv_bench_mon #(
    parameter int NUM_EVENTS      = 4,
    parameter int CNT_WIDTH       = 64,
    parameter int WATCHDOG_CYCLES = 500_000_000,
    parameter int WATCHDOG_WIDTH  = 32,
    parameter int WD_MODE         = 0
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             clr_i,
    input  logic                             start_i,
    input  logic                             stop_i,
    input  logic                             retire_i,
    input  logic                             halt_i,
    input  logic [NUM_EVENTS-1:0]            event_in_i,
    output logic [CNT_WIDTH-1:0]             cycle_cnt_o,
    output logic [CNT_WIDTH-1:0]             instret_cnt_o,
    output logic [NUM_EVENTS*CNT_WIDTH-1:0]  event_cnt_o,
    output logic [1:0]                       state_o,
    output logic                             done_o,
    output logic                             timeout_o
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_PAUSE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam bit WD_EN = (WATCHDOG_CYCLES != 0);
    localparam logic [WATCHDOG_WIDTH-1:0] WD_LAST = WATCHDOG_WIDTH'(WATCHDOG_CYCLES - 1);

    generate
        if (NUM_EVENTS < 1 || NUM_EVENTS > 16) begin : g_bad_num_events
            $fatal(1, "svc_rv_bench_mon: NUM_EVENTS must be 1..16");
        end
        if (WATCHDOG_CYCLES < 0 || (64'(WATCHDOG_CYCLES) >> WATCHDOG_WIDTH) != 64'd0) begin : g_bad_wd
            $fatal(1, "svc_rv_bench_mon: WATCHDOG_CYCLES does not fit WATCHDOG_WIDTH");
        end
    endgenerate

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v, input logic inc);
        return (inc && v != '1) ? v + CNT_WIDTH'(1) : v;
    endfunction

    logic [1:0]                state_q, state_d;
    logic                      done_q, done_d;
    logic                      timeout_q, timeout_d;
    logic [WATCHDOG_WIDTH-1:0] wd_q, wd_d;
    logic [CNT_WIDTH-1:0]      cyc_q, cyc_d;
    logic [CNT_WIDTH-1:0]      ins_q, ins_d;
    logic [CNT_WIDTH-1:0]      ev_q [NUM_EVENTS];

    logic run, live, go, wd_reload, expire;

    always_comb begin
        run       = (state_q == S_RUN);
        live      = (state_q != S_DONE);
        go        = start_i && !stop_i;
        wd_reload = (WD_MODE == 1) && retire_i;
        expire    = WD_EN && live && !wd_reload && (wd_q == WD_LAST);

        state_d = state_q;
        case (state_q)
            S_IDLE:  if (halt_i) state_d = S_DONE; else if (go) state_d = S_RUN;
            S_RUN:   if (halt_i) state_d = S_DONE; else if (stop_i) state_d = S_PAUSE;
            S_PAUSE: if (halt_i) state_d = S_DONE; else if (go) state_d = S_RUN;
            default: state_d = S_DONE;
        endcase
        // halt takes priority, so a coincident expiry never marks a timeout
        if (expire) state_d = S_DONE;
        timeout_d = timeout_q | (expire && !halt_i);
        done_d    = live && (state_d == S_DONE);

        if (!WD_EN)         wd_d = '0;
        else if (!live)     wd_d = wd_q;
        else if (wd_reload) wd_d = '0;
        else                wd_d = wd_q + WATCHDOG_WIDTH'(1);

        cyc_d = sat_inc(cyc_q, run);
        ins_d = sat_inc(ins_q, run && retire_i);

        if (clr_i) begin
            state_d   = S_IDLE;
            timeout_d = 1'b0;
            done_d    = 1'b0;
            wd_d      = '0;
            cyc_d     = '0;
            ins_d     = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            wd_q      <= '0;
            cyc_q     <= '0;
            ins_q     <= '0;
        end else begin
            state_q   <= state_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
            wd_q      <= wd_d;
            cyc_q     <= cyc_d;
            ins_q     <= ins_d;
        end
    end

    for (genvar g = 0; g < NUM_EVENTS; g++) begin : g_ev
        logic [CNT_WIDTH-1:0] ev_d;
        assign ev_d = clr_i ? '0 : sat_inc(ev_q[g], run && event_in_i[g]);
        always_ff @(posedge clk_i) begin
            if (rst_i) ev_q[g] <= '0;
            else       ev_q[g] <= ev_d;
        end
        assign event_cnt_o[g*CNT_WIDTH +: CNT_WIDTH] = ev_q[g];
    end

    assign cycle_cnt_o   = cyc_q;
    assign instret_cnt_o = ins_q;
    assign state_o       = state_q;
    assign done_o        = done_q;
    assign timeout_o     = timeout_q;

endmodule
